// File: rtl/lzrw1_pkg.sv
// lzrw1_pkg: shared constants and FSM state type for the LZRW1 job arbiter.
//   BYTE_W        : data byte width shared by requesters, core and output.
//   CORE_RESET_ON : level that restarts the compression core.
//   state_e       : job FSM states IDLE -> CLEAR -> STREAM -> DRAIN -> DONE.
package lzrw1_pkg;
   localparam int   BYTE_W        = 8;
   localparam logic CORE_RESET_ON = 1'b1;
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;
endpackage

// File: rtl/lzrw1_rr_grant.sv
// lzrw1_rr_grant: two-way round-robin grant selection.
//   req_i        : request vector (bit N = requester N valid).
//   last_grant_i : requester granted by the previous completed job.
//   grant_o      : selected requester; only meaningful when any req_i bit is set.
module lzrw1_rr_grant (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic       grant_o
);
   // Contention goes to the requester not served last; otherwise the lone requester wins.
   always_comb grant_o = (&req_i) ? ~last_grant_i : req_i[1];
endmodule

// File: rtl/lzrw1_job_arbiter.sv
// lzrw1_job_arbiter: shares one LZRW1 compression core between two byte requesters.
//   clock, reset            : rising-edge clock, synchronous active-low reset.
//   reqN_valid/byte/last    : requester N byte stream; reqN_ready accepts it.
//   core_reset              : core restart (one CLEAR cycle per job, and during reset).
//   core_valid/core_byte    : accepted byte, presented one cycle after the handshake.
//   core_out_valid/byte     : core output, forwarded as out_valid/out_byte/out_owner.
//   core_finished           : core completion, honoured only in DRAIN.
//   job_done/job_owner      : one-cycle completion pulse and the job's requester.
//   timeout_err             : one-cycle pulse when DRAIN expires without core_finished.
module lzrw1_job_arbiter
   import lzrw1_pkg::*;
#(
   parameter int BLOCK_LEN     = 16,
   parameter int DRAIN_TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [BYTE_W-1:0] req0_byte,
   input  logic              req0_last,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [BYTE_W-1:0] req1_byte,
   input  logic              req1_last,
   output logic              req1_ready,
   output logic              core_reset,
   output logic              core_valid,
   output logic [BYTE_W-1:0] core_byte,
   input  logic              core_out_valid,
   input  logic [BYTE_W-1:0] core_out_byte,
   input  logic              core_finished,
   output logic              out_valid,
   output logic [BYTE_W-1:0] out_byte,
   output logic              out_owner,
   output logic              job_done,
   output logic              job_owner,
   output logic              timeout_err
);
   localparam logic [7:0] LAST_IDX = 8'(BLOCK_LEN - 1);
   localparam logic [7:0] TMO_IDX  = 8'(DRAIN_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic              grant_q, last_grant_q, rr_grant;
   logic [7:0]        cnt_q, drain_q;
   logic              core_valid_q, out_valid_q, out_owner_q, timeout_q;
   logic [BYTE_W-1:0] core_byte_q, out_byte_q;
   logic              sel_valid, sel_last, accept, fwd, any_req, tmo_hit;
   logic [BYTE_W-1:0] sel_byte;

   lzrw1_rr_grant u_rr (
      .req_i        ({req1_valid, req0_valid}),
      .last_grant_i (last_grant_q),
      .grant_o      (rr_grant)
   );

   always_comb begin
      any_req   = req0_valid | req1_valid;
      sel_valid = grant_q ? req1_valid : req0_valid;
      sel_byte  = grant_q ? req1_byte  : req0_byte;
      sel_last  = grant_q ? req1_last  : req0_last;
      accept    = (state_q == ST_STREAM) && sel_valid;
      fwd       = core_out_valid && (state_q == ST_STREAM || state_q == ST_DRAIN);
      // Finishing on the expiry cycle itself is treated as success.
      tmo_hit   = (state_q == ST_DRAIN) && !core_finished && (drain_q == TMO_IDX);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = any_req ? ST_CLEAR : ST_IDLE;
         ST_CLEAR:  state_d = ST_STREAM;
         // Whichever of last-flag or block-length comes first ends the job; both together is one exit.
         ST_STREAM: state_d = (accept && (sel_last || cnt_q == LAST_IDX)) ? ST_DRAIN : ST_STREAM;
         ST_DRAIN:  state_d = (core_finished || drain_q == TMO_IDX) ? ST_DONE : ST_DRAIN;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         drain_q      <= '0;
         core_valid_q <= 1'b0;
         core_byte_q  <= '0;
         out_valid_q  <= 1'b0;
         out_byte_q   <= '0;
         out_owner_q  <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= (state_q == ST_IDLE && any_req) ? rr_grant : grant_q;
         last_grant_q <= (state_q == ST_DONE) ? grant_q : last_grant_q;
         cnt_q        <= (state_q == ST_CLEAR) ? '0 : (accept ? cnt_q + 8'd1 : cnt_q);
         drain_q      <= (state_q == ST_DRAIN) ? drain_q + 8'd1 : '0;
         core_valid_q <= accept;
         core_byte_q  <= accept ? sel_byte : '0;
         out_valid_q  <= fwd;
         out_byte_q   <= fwd ? core_out_byte : '0;
         out_owner_q  <= fwd & grant_q;
         timeout_q    <= tmo_hit;
      end
   end

   always_comb begin
      req0_ready  = (state_q == ST_STREAM) && !grant_q;
      req1_ready  = (state_q == ST_STREAM) && grant_q;
      core_reset  = (!reset || state_q == ST_CLEAR) ? CORE_RESET_ON : ~CORE_RESET_ON;
      core_valid  = core_valid_q;
      core_byte   = core_byte_q;
      out_valid   = out_valid_q;
      out_byte    = out_byte_q;
      out_owner   = out_owner_q;
      job_done    = (state_q == ST_DONE);
      job_owner   = (state_q == ST_DONE) & grant_q;
      timeout_err = timeout_q;
   end
endmodule
